cordic_shift_sequencer: RTL and testbench

Iteration sequencer for the hyperbolic CORDIC exponential datapath. It generates, on the fly, the iteration index and matching right-shift amount for every micro-rotation, including the mandatory repeated iterations at shifts 4 and 13 (the 3k+1 rule). It replaces a table lookup with a counter-based schedule. It paces the rotation datapath with a valid/ready step handshake.

---
 rtl/cordic_shift_sequencer_pkg.sv | 15 +
 rtl/cordic_shift_sequencer_repeat_tracker.sv | 60 ++++++
 rtl/cordic_shift_sequencer.sv | 158 +++++++++++++++
 tb/tb_cordic_shift_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_shift_sequencer_pkg.sv
// Shared definitions for the hyperbolic CORDIC iteration sequencer.
package cordic_shift_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } seq_state_t;

   // Shift of the first repeated iteration; later ones follow RK -> 3*RK+1.
   localparam int REPEAT_SEED = 4;
   localparam int REPEAT_MULT = 3;
   localparam int ADRS_W      = 5;

endpackage

// File: rtl/cordic_shift_sequencer_repeat_tracker.sv
// Owns the repeat target RK and derives the next SHIFT/REPEAT pair of the schedule.
module cordic_repeat_tracker
   import cordic_shift_sequencer_pkg::*;
#(
   parameter int P = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic [ADRS_W-1:0] i_adrs,
   input  logic [P-1:0]      i_shift,
   input  logic              i_repeat,
   output logic [P-1:0]      o_next_shift,
   output logic              o_next_repeat
);

   localparam int              RK_W    = P + 2;
   localparam int              PROD_W  = RK_W + 2;
   localparam logic [RK_W-1:0] RK_SEED = RK_W'(REPEAT_SEED);

   logic [RK_W-1:0]   r_rk;
   logic [PROD_W-1:0] w_rk_prod;
   logic [RK_W-1:0]   w_rk_grown;
   logic              w_pre_step;
   logic              w_hit;

   // Two spare bits catch overflow of 3*RK+1; on overflow RK pins to all-ones,
   // which no P-bit shift can ever equal, so repeats stop.
   assign w_rk_prod  = PROD_W'(REPEAT_MULT) * {2'b00, r_rk} + PROD_W'(1);
   assign w_rk_grown = (w_rk_prod[PROD_W-1 -: 2] != 2'b00) ? '1 : w_rk_prod[RK_W-1:0];
   assign w_pre_step = (i_adrs == '0);
   assign w_hit      = !w_pre_step && !i_repeat && (RK_W'(i_shift) == r_rk);

   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      o_next_shift  = i_shift;
      o_next_repeat = 1'b0;
      if (w_pre_step) begin
         o_next_shift  = '0;
         o_next_repeat = 1'b1;
      end else if (w_hit) begin
         o_next_repeat = 1'b1;
      end else if (i_shift != '1) begin
         o_next_shift = i_shift + P'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rk <= RK_SEED;
      end else if (i_load) begin
         r_rk <= RK_SEED;
      end else if (i_advance && w_hit) begin
         r_rk <= w_rk_grown;
      end
   end

endmodule

// File: rtl/cordic_shift_sequencer.sv
// Run FSM and step handshake for the CORDIC exponential iteration schedule.
module cordic_shift_sequencer
   import cordic_shift_sequencer_pkg::*;
#(
   parameter int P      = 5,
   parameter int N_ITER = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_clr,
   input  logic              i_step_ready,
   output logic              o_step_valid,
   output logic [ADRS_W-1:0] o_adrs,
   output logic [P-1:0]      o_shift,
   output logic              o_repeat,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADRS_W-1:0] LAST_ADRS = ADRS_W'(N_ITER - 1);

   seq_state_t        r_state;
   logic              r_valid;
   logic [ADRS_W-1:0] r_adrs;
   logic [P-1:0]      r_shift;
   logic              r_repeat;
   logic              r_last;
   logic              r_busy;
   logic              r_done;

   seq_state_t        w_nxt_state;
   logic              w_nxt_valid;
   logic [ADRS_W-1:0] w_nxt_adrs;
   logic [P-1:0]      w_nxt_shift;
   logic              w_nxt_repeat;
   logic              w_nxt_last;
   logic              w_nxt_busy;
   logic              w_nxt_done;

   logic              w_accept;
   logic              w_load;
   logic              w_advance;
   logic [P-1:0]      w_trk_shift;
   logic              w_trk_repeat;

   assign w_accept = r_valid && i_step_ready;

   cordic_repeat_tracker #(
      .P (P)
   ) u_tracker (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_load        (w_load),
      .i_advance     (w_advance),
      .i_adrs        (r_adrs),
      .i_shift       (r_shift),
      .i_repeat      (r_repeat),
      .o_next_shift  (w_trk_shift),
      .o_next_repeat (w_trk_repeat)
   );

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_valid  = r_valid;
      w_nxt_adrs   = r_adrs;
      w_nxt_shift  = r_shift;
      w_nxt_repeat = r_repeat;
      w_nxt_last   = r_last;
      w_nxt_busy   = r_busy;
      w_nxt_done   = 1'b0;
      w_load       = 1'b0;
      w_advance    = 1'b0;

      if (i_clr) begin
         w_nxt_state  = ST_IDLE;
         w_nxt_valid  = 1'b0;
         w_nxt_adrs   = '0;
         w_nxt_shift  = '0;
         w_nxt_repeat = 1'b0;
         w_nxt_last   = 1'b0;
         w_nxt_busy   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_nxt_state  = ST_RUN;
                  w_nxt_valid  = 1'b1;
                  w_nxt_adrs   = '0;
                  w_nxt_shift  = '0;
                  w_nxt_repeat = 1'b0;
                  w_nxt_last   = 1'b0;
                  w_nxt_busy   = 1'b1;
                  w_load       = 1'b1;
               end
            end
            ST_RUN: begin
               // Without acceptance every output register simply holds.
               if (w_accept) begin
                  if (r_last) begin
                     w_nxt_state = ST_FIN;
                     w_nxt_valid = 1'b0;
                     w_nxt_last  = 1'b0;
                     w_nxt_busy  = 1'b0;
                     w_nxt_done  = 1'b1;
                  end else begin
                     w_nxt_adrs   = r_adrs + ADRS_W'(1);
                     w_nxt_shift  = w_trk_shift;
                     w_nxt_repeat = w_trk_repeat;
                     w_nxt_last   = (r_adrs + ADRS_W'(1)) == LAST_ADRS;
                     w_advance    = 1'b1;
                  end
               end
            end
            ST_FIN: begin
               w_nxt_state = ST_IDLE;
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_valid = 1'b0;
               w_nxt_busy  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0;
         r_adrs   <= '0;
         r_shift  <= '0;
         r_repeat <= 1'b0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_valid  <= w_nxt_valid;
         r_adrs   <= w_nxt_adrs;
         r_shift  <= w_nxt_shift;
         r_repeat <= w_nxt_repeat;
         r_last   <= w_nxt_last;
         r_busy   <= w_nxt_busy;
         r_done   <= w_nxt_done;
      end
   end

   assign o_step_valid = r_valid;
   assign o_adrs       = r_adrs;
   assign o_shift      = r_shift;
   assign o_repeat     = r_repeat;
   assign o_last       = r_last;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_cordic_shift_sequencer.sv
// Self-checking bench: cycle-level reference model of the run/step protocol plus a
// schedule generated directly from the 3k+1 repeat rule.
module tb_cordic_shift_sequencer;

   localparam int P   = 5;
   localparam int N32 = 32;
   localparam int N5  = 5;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_start;
   logic       i_clr;
   logic       i_step_ready;
   logic       o_step_valid;
   logic [4:0] o_adrs;
   logic [P-1:0] o_shift;
   logic       o_repeat;
   logic       o_last;
   logic       o_busy;
   logic       o_done;

   logic       i_start5;
   logic       i_clr5;
   logic       i_step_ready5;
   logic       o_step_valid5;
   logic [4:0] o_adrs5;
   logic [P-1:0] o_shift5;
   logic       o_repeat5;
   logic       o_last5;
   logic       o_busy5;
   logic       o_done5;

   cordic_shift_sequencer #(.P(P), .N_ITER(N32)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_clr        (i_clr),
      .i_step_ready (i_step_ready),
      .o_step_valid (o_step_valid),
      .o_adrs       (o_adrs),
      .o_shift      (o_shift),
      .o_repeat     (o_repeat),
      .o_last       (o_last),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   cordic_shift_sequencer #(.P(P), .N_ITER(N5)) dut5 (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start5),
      .i_clr        (i_clr5),
      .i_step_ready (i_step_ready5),
      .o_step_valid (o_step_valid5),
      .o_adrs       (o_adrs5),
      .o_shift      (o_shift5),
      .o_repeat     (o_repeat5),
      .o_last       (o_last5),
      .o_busy       (o_busy5),
      .o_done       (o_done5)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec;
   int n_err;
   int edge_n;
   int obs_done_edge;
   int n_done_obs;

   // Reference model state.
   bit m_active;
   bit m_done;
   int m_idx;
   int m_start_edge;

   int exp_shift[N32];
   bit exp_rep[N32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Schedule: pre-step 0, then each shift k once, with a second (REPEAT) copy when
   // k hits the target 4, 13, 40, ...
   task automatic build_schedule();
      int i;
      int k;
      int rk;
      exp_shift[0] = 0; exp_rep[0] = 1'b0;
      exp_shift[1] = 0; exp_rep[1] = 1'b1;
      i  = 2;
      k  = 1;
      rk = 4;
      while (i < N32) begin
         exp_shift[i] = k; exp_rep[i] = 1'b0;
         i++;
         if (k == rk && i < N32) begin
            exp_shift[i] = k; exp_rep[i] = 1'b1;
            i++;
            rk = (3 * rk + 1 > 127) ? 127 : 3 * rk + 1;
         end
         if (k < 31) k++;
      end
   endtask

   task automatic compare();
      if (o_done === 1'b1) begin
         obs_done_edge = edge_n;
         n_done_obs++;
      end
      check("valid", 32'(o_step_valid), 32'(m_active));
      check("busy",  32'(o_busy),       32'(m_active));
      check("done",  32'(o_done),       32'(m_done));
      if (m_active) begin
         check("adrs",   32'(o_adrs),   m_idx);
         check("shift",  32'(o_shift),  exp_shift[m_idx]);
         check("repeat", 32'(o_repeat), 32'(exp_rep[m_idx]));
         check("last",   32'(o_last),   32'(m_idx == N32 - 1));
      end
   endtask

   // Drive one clock of inputs, advance the model across the edge, then compare.
   task automatic cycle(input bit st, input bit rdy, input bit cl);
      i_start      = st;
      i_step_ready = rdy;
      i_clr        = cl;
      if (cl) begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active) begin
         if (st) begin
            m_active     = 1'b1;
            m_idx        = 0;
            m_start_edge = edge_n + 1;
         end
      end else if (rdy) begin
         if (m_idx == N32 - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end else begin
            m_idx++;
         end
      end
      @(negedge i_clk);
      edge_n++;
      compare();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"},  32'(o_step_valid), 0);
      check({tag, "_adrs"},   32'(o_adrs),       0);
      check({tag, "_shift"},  32'(o_shift),      0);
      check({tag, "_repeat"}, 32'(o_repeat),     0);
      check({tag, "_last"},   32'(o_last),       0);
      check({tag, "_busy"},   32'(o_busy),       0);
      check({tag, "_done"},   32'(o_done),       0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      int done_before;
      n_vec = 0; n_err = 0; edge_n = 0; n_done_obs = 0; obs_done_edge = -1;
      m_active = 1'b0; m_done = 1'b0; m_idx = 0; m_start_edge = 0;
      i_rst_n = 1'b0; i_start = 1'b0; i_clr = 1'b0; i_step_ready = 1'b0;
      i_start5 = 1'b0; i_clr5 = 1'b0; i_step_ready5 = 1'b1;
      build_schedule();

      // Reset state
      repeat (2) @(negedge i_clk);
      check_reset_values("reset");
      i_rst_n = 1'b1;

      // Full run, ready tied high: DONE lands N edges after the START edge
      obs_done_edge = -1;
      cycle(1'b1, 1'b1, 1'b0);
      repeat (N32 + 2) cycle(1'b0, 1'b1, 1'b0);
      check("done_latency_full", obs_done_edge - m_start_edge, N32);

      // Ready toggling 1,0,1,0: DONE in cycle 2N after START
      obs_done_edge = -1;
      cycle(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 2 * N32 + 2; k++) cycle(1'b0, bit'(k % 2), 1'b0);
      check("done_latency_toggle", obs_done_edge - m_start_edge, 2 * N32 - 1);

      // CLR at ADRS 10, no DONE afterwards, restart from index 0
      done_before = n_done_obs;
      cycle(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (!(m_active && m_idx == 10) && guard < 40) begin
         cycle(1'b0, 1'b1, 1'b0);
         guard++;
      end
      check("clr_reached_adrs10", 32'(o_adrs), 10);
      cycle(1'b0, 1'b1, 1'b1);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      check("clr_no_done", n_done_obs - done_before, 0);
      cycle(1'b1, 1'b1, 1'b0);
      check("clr_restart_adrs",  32'(o_adrs),  0);
      check("clr_restart_shift", 32'(o_shift), 0);
      repeat (N32 + 2) cycle(1'b0, 1'b1, 1'b0);

      // Asynchronous reset at ADRS 7, then a fresh schedule
      cycle(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (!(m_active && m_idx == 7) && guard < 40) begin
         cycle(1'b0, 1'b1, 1'b0);
         guard++;
      end
      check("rst_reached_adrs7", 32'(o_adrs), 7);
      #2 i_rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      m_active = 1'b0; m_done = 1'b0;
      i_start = 1'b0;
      @(negedge i_clk);
      edge_n++;
      i_rst_n = 1'b1;
      compare();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3 * N32 && (m_active || m_done); k++)
         cycle(1'b0, bit'($urandom_range(0, 1)), 1'b0);
      check("rst_run_finished", 32'(m_active || m_done), 0);

      // START held high: back-to-back runs, the second starting the cycle after DONE
      done_before = n_done_obs;
      for (int k = 0; k < 2 * N32 + 6; k++) cycle(1'b1, 1'b1, 1'b0);
      check("held_start_runs", n_done_obs - done_before, 2);
      cycle(1'b0, 1'b1, 1'b1);

      // Randomized traffic: stray STARTs, random ready, occasional CLR
      for (int k = 0; k < 400; k++)
         cycle(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 49) == 0));
      cycle(1'b0, 1'b1, 1'b1);

      // Short configuration: five iterations, DONE six cycles after START
      i_start5 = 1'b1;
      @(negedge i_clk);
      i_start5 = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c <= N5) begin
            check("n5_valid",  32'(o_step_valid5), 1);
            check("n5_adrs",   32'(o_adrs5),       c - 1);
            check("n5_shift",  32'(o_shift5),      exp_shift[c - 1]);
            check("n5_repeat", 32'(o_repeat5),     32'(exp_rep[c - 1]));
            check("n5_last",   32'(o_last5),       32'(c - 1 == N5 - 1));
            check("n5_done",   32'(o_done5),       0);
         end else begin
            check("n5_valid_end", 32'(o_step_valid5), 0);
            check("n5_done_end",  32'(o_done5),       32'(c == N5 + 1));
         end
         @(negedge i_clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
